// File: rtl/tcam_masked.sv
// Ternary CAM with per-entry care masks and valid bits, lowest-index priority search,
// multi-match flag and registered occupancy status. Reads and searches see pre-edge contents.
module tcam_masked #(
  parameter int DATA_WIDTH      = 32,
  parameter int ARRAY_SIZE_LOG2 = 5
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic                       write_i,
  input  logic [ARRAY_SIZE_LOG2-1:0] write_index_i,
  input  logic [DATA_WIDTH-1:0]      write_data_i,
  input  logic [DATA_WIDTH-1:0]      write_mask_i,
  input  logic                       inval_i,
  input  logic [ARRAY_SIZE_LOG2-1:0] inval_index_i,
  input  logic                       read_i,
  input  logic [ARRAY_SIZE_LOG2-1:0] read_index_i,
  input  logic                       search_i,
  input  logic [DATA_WIDTH-1:0]      search_data_i,
  output logic                       read_valid_o,
  output logic [DATA_WIDTH-1:0]      read_value_o,
  output logic [DATA_WIDTH-1:0]      read_mask_o,
  output logic                       search_valid_o,
  output logic [ARRAY_SIZE_LOG2-1:0] search_index_o,
  output logic                       search_multi_o,
  output logic [ARRAY_SIZE_LOG2:0]   count_o,
  output logic                       full_o
);
  localparam int N = 2 ** ARRAY_SIZE_LOG2;
  localparam logic [ARRAY_SIZE_LOG2:0] FULL_COUNT = (ARRAY_SIZE_LOG2 + 1)'(N);

  logic [DATA_WIDTH-1:0]      data_q [N];
  logic [DATA_WIDTH-1:0]      mask_q [N];
  logic [N-1:0]               valid_q;
  logic [N-1:0]               valid_nxt;
  logic [N-1:0]               hit;
  logic [ARRAY_SIZE_LOG2-1:0] hit_index;
  logic                       hit_any;
  logic                       hit_multi;
  logic [ARRAY_SIZE_LOG2:0]   count_nxt;

  always_comb begin
    hit = '0;
    for (int e = 0; e < N; e++) begin
      hit[e] = valid_q[e] && (((search_data_i ^ data_q[e]) & mask_q[e]) == '0);
    end
  end

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    hit_index = '0;
    hit_any   = 1'b0;
    hit_multi = 1'b0;
    for (int e = N - 1; e >= 0; e--) begin
      if (hit[e]) begin
        if (hit_any) hit_multi = 1'b1;
        hit_any   = 1'b1;
        hit_index = ARRAY_SIZE_LOG2'(e);
      end
    end
  end

  // Invalidate is applied after write so a same-index pair leaves the entry invalid.
  always_comb begin
    valid_nxt = valid_q;
    if (clear_i) begin
      valid_nxt = '0;
    end else begin
      if (write_i) valid_nxt[write_index_i] = 1'b1;
      if (inval_i) valid_nxt[inval_index_i] = 1'b0;
    end
  end

  always_comb begin
    count_nxt = '0;
    for (int e = 0; e < N; e++) begin
      count_nxt = count_nxt + {{ARRAY_SIZE_LOG2{1'b0}}, valid_nxt[e]};
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      for (int e = 0; e < N; e++) begin
        data_q[e] <= '0;
        mask_q[e] <= '0;
      end
      valid_q <= '0;
      count_o <= '0;
      full_o  <= 1'b0;
    end else begin
      if (write_i && !clear_i) begin
        data_q[write_index_i] <= write_data_i;
        mask_q[write_index_i] <= write_mask_i;
      end
      valid_q <= valid_nxt;
      count_o <= count_nxt;
      full_o  <= (count_nxt == FULL_COUNT);
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      read_valid_o   <= 1'b0;
      read_value_o   <= '0;
      read_mask_o    <= '0;
      search_valid_o <= 1'b0;
      search_index_o <= '0;
      search_multi_o <= 1'b0;
    end else begin
      read_valid_o <= read_i && valid_q[read_index_i];
      if (read_i) begin
        read_value_o <= valid_q[read_index_i] ? data_q[read_index_i] : '0;
        read_mask_o  <= valid_q[read_index_i] ? mask_q[read_index_i] : '0;
      end
      if (search_i) begin
        search_valid_o <= hit_any;
        search_index_o <= hit_index;
        search_multi_o <= hit_multi;
      end
    end
  end
endmodule

// File: tb/tb_tcam_masked.sv
// Self-checking bench for tcam_masked: directed vector table, hand-written corner sequences
// and randomized traffic, all checked against an array-based reference model.
module tb_tcam_masked;
  localparam logic [31:0] FULL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        clear_i = 1'b0, write_i = 1'b0, inval_i = 1'b0, read_i = 1'b0, search_i = 1'b0;
  logic [4:0]  write_index_i = '0, inval_index_i = '0, read_index_i = '0;
  logic [31:0] write_data_i = '0, write_mask_i = '0, search_data_i = '0;
  logic        read_valid_o, search_valid_o, search_multi_o, full_o;
  logic [31:0] read_value_o, read_mask_o;
  logic [4:0]  search_index_o;
  logic [5:0]  count_o;

  tcam_masked #(.DATA_WIDTH(32), .ARRAY_SIZE_LOG2(5)) dut (
    .clk(clk), .reset_i(reset_i), .clear_i(clear_i),
    .write_i(write_i), .write_index_i(write_index_i), .write_data_i(write_data_i),
    .write_mask_i(write_mask_i), .inval_i(inval_i), .inval_index_i(inval_index_i),
    .read_i(read_i), .read_index_i(read_index_i), .search_i(search_i),
    .search_data_i(search_data_i), .read_valid_o(read_valid_o), .read_value_o(read_value_o),
    .read_mask_o(read_mask_o), .search_valid_o(search_valid_o), .search_index_o(search_index_o),
    .search_multi_o(search_multi_o), .count_o(count_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Reference model
  logic        m_valid [32];
  logic [31:0] m_data  [32];
  logic [31:0] m_mask  [32];
  logic        e_rv, e_sv, e_sm;
  logic [31:0] e_rval, e_rmask;
  logic [4:0]  e_si;

  typedef struct packed {
    logic        clr;
    logic        wr;
    logic [4:0]  widx;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic        inv;
    logic [4:0]  iidx;
    logic        rd;
    logic [4:0]  ridx;
    logic        srch;
    logic [31:0] sdata;
    logic        cs;
    logic        sv;
    logic [4:0]  si;
    logic        sm;
    logic        cr;
    logic        rv;
    logic [31:0] rval;
    logic [31:0] rmask;
    logic        cc;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int e = 0; e < 32; e++) n += int'(m_valid[e]);
    return n;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < 32; e++) begin
      m_valid[e] = 1'b0; m_data[e] = '0; m_mask[e] = '0;
    end
    e_rv = 0; e_rval = '0; e_rmask = '0; e_sv = 0; e_si = '0; e_sm = 0;
  endtask

  task automatic model_edge();
    int n;
    int first;
    if (search_i) begin
      n = 0; first = 0;
      for (int e = 0; e < 32; e++) begin
        if (m_valid[e] && (((search_data_i ^ m_data[e]) & m_mask[e]) == 32'd0)) begin
          if (n == 0) first = e;
          n++;
        end
      end
      e_sv = (n > 0); e_si = 5'(first); e_sm = (n > 1);
    end
    if (read_i) begin
      e_rv    = m_valid[read_index_i];
      e_rval  = m_valid[read_index_i] ? m_data[read_index_i] : 32'd0;
      e_rmask = m_valid[read_index_i] ? m_mask[read_index_i] : 32'd0;
    end else begin
      e_rv = 1'b0;
    end
    if (clear_i) begin
      for (int e = 0; e < 32; e++) m_valid[e] = 1'b0;
    end else begin
      if (write_i) begin
        m_valid[write_index_i] = 1'b1;
        m_data[write_index_i]  = write_data_i;
        m_mask[write_index_i]  = write_mask_i;
      end
      if (inval_i) m_valid[inval_index_i] = 1'b0;
    end
  endtask

  task automatic check_model();
    int c;
    c = model_count();
    chk("read_valid", read_valid_o, e_rv);
    chk("read_value", read_value_o, e_rval);
    chk("read_mask", read_mask_o, e_rmask);
    chk("search_valid", search_valid_o, e_sv);
    chk("search_index", search_index_o, e_si);
    chk("search_multi", search_multi_o, e_sm);
    chk("count", count_o, c);
    chk("full", full_o, c == 32);
  endtask

  task automatic idle();
    clear_i = 0; write_i = 0; inval_i = 0; read_i = 0; search_i = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    idle();
  endtask

  task automatic drive(input vec_t v);
    clear_i = v.clr; write_i = v.wr; write_index_i = v.widx; write_data_i = v.wdata;
    write_mask_i = v.wmask; inval_i = v.inv; inval_index_i = v.iidx; read_i = v.rd;
    read_index_i = v.ridx; search_i = v.srch; search_data_i = v.sdata;
  endtask

  function automatic vec_t f_wr(input logic [4:0] i, input logic [31:0] d, input logic [31:0] m);
    vec_t v = '0;
    v.wr = 1; v.widx = i; v.wdata = d; v.wmask = m;
    return v;
  endfunction

  function automatic vec_t f_sr(input logic [31:0] k, input logic sv, input logic [4:0] si,
                                input logic sm);
    vec_t v = '0;
    v.srch = 1; v.sdata = k; v.cs = 1; v.sv = sv; v.si = si; v.sm = sm;
    return v;
  endfunction

  task automatic write1(input logic [4:0] i, input logic [31:0] d, input logic [31:0] m);
    drive(f_wr(i, d, m));
    cycle();
  endtask

  task automatic search1(input logic [31:0] k);
    search_i = 1; search_data_i = k;
    cycle();
  endtask

  vec_t v;

  initial begin
    model_reset();
    #12;
    chk("reset_search_valid", search_valid_o, 1'b0);
    chk("reset_read_valid", read_valid_o, 1'b0);
    chk("reset_count", count_o, 6'd0);
    chk("reset_full", full_o, 1'b0);
    reset_i = 0;

    // Directed table
    tbl.push_back(f_wr(1, 1, FULL));
    tbl.push_back(f_wr(3, 3, FULL));
    tbl.push_back(f_wr(5, 5, FULL));
    tbl.push_back(f_wr(7, 7, FULL));
    v = f_sr(5, 1, 5, 0); v.cc = 1; v.cnt = 4; tbl.push_back(v);
    tbl.push_back(f_wr(2, 0, 32'hFFFF_FFF0));
    tbl.push_back(f_wr(9, 5, FULL));
    v = f_sr(5, 1, 2, 1); v.cc = 1; v.cnt = 6; tbl.push_back(v);
    v = '0; v.rd = 1; v.ridx = 4; v.cr = 1; v.rv = 0; v.rval = 0; v.rmask = 0; tbl.push_back(v);
    v = f_wr(5, 9, FULL); v.rd = 1; v.ridx = 5; v.cr = 1; v.rv = 1; v.rval = 5; v.rmask = FULL;
    tbl.push_back(v);
    v = '0; v.rd = 1; v.ridx = 5; v.cr = 1; v.rv = 1; v.rval = 9; v.rmask = FULL; tbl.push_back(v);
    v = f_sr(5, 1, 2, 1); v.inv = 1; v.iidx = 2; v.cc = 1; v.cnt = 5; tbl.push_back(v);
    v = f_sr(5, 1, 9, 0); v.cc = 1; v.cnt = 5; tbl.push_back(v);
    v = f_wr(7, 7, FULL); v.inv = 1; v.iidx = 7; v.cc = 1; v.cnt = 4; tbl.push_back(v);
    v = f_sr(7, 0, 0, 0); v.inv = 1; v.iidx = 7; v.cc = 1; v.cnt = 4; tbl.push_back(v);
    // new write plus invalidate of a different valid entry: count unchanged
    v = f_wr(12, 12, FULL); v.inv = 1; v.iidx = 1; v.cc = 1; v.cnt = 4; tbl.push_back(v);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      cycle();
      if (tbl[i].cs) begin
        chk($sformatf("tbl%0d_sv", i), search_valid_o, tbl[i].sv);
        chk($sformatf("tbl%0d_si", i), search_index_o, tbl[i].si);
        chk($sformatf("tbl%0d_sm", i), search_multi_o, tbl[i].sm);
      end
      if (tbl[i].cr) begin
        chk($sformatf("tbl%0d_rv", i), read_valid_o, tbl[i].rv);
        chk($sformatf("tbl%0d_rval", i), read_value_o, tbl[i].rval);
        chk($sformatf("tbl%0d_rmask", i), read_mask_o, tbl[i].rmask);
      end
      if (tbl[i].cc) chk($sformatf("tbl%0d_count", i), count_o, tbl[i].cnt);
    end

    // Fill, overwrite while full, clear
    for (int i = 0; i < 32; i++) write1(5'(i), 32'(100 + i), FULL);
    chk("fill_count", count_o, 6'd32);
    chk("fill_full", full_o, 1'b1);
    write1(3, 32'h55, FULL);
    chk("full_overwrite_count", count_o, 6'd32);
    chk("full_overwrite_full", full_o, 1'b1);
    clear_i = 1; write_i = 1; write_index_i = 4;
    cycle();
    chk("clear_count", count_o, 6'd0);
    chk("clear_full", full_o, 1'b0);
    search1(32'd104);
    chk("clear_search_miss", search_valid_o, 1'b0);

    // Zero mask matches any key
    write1(20, 32'hABC, 32'h0);
    search1(32'h1234_5678);
    chk("zero_mask_sv", search_valid_o, 1'b1);
    chk("zero_mask_si", search_index_o, 5'd20);
    write1(10, 32'h0, 32'h0);
    search1(32'hDEAD_BEEF);
    chk("zero_mask2_si", search_index_o, 5'd10);
    chk("zero_mask2_sm", search_multi_o, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      clear_i = ($urandom_range(0, 99) < 2);
      write_i = ($urandom_range(0, 99) < 45);
      write_index_i = 5'($urandom_range(0, 31));
      write_data_i = 32'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: write_mask_i = FULL;
        1: write_mask_i = 32'hFFFF_FFF8;
        2: write_mask_i = 32'hFFFF_FFFC;
        3: write_mask_i = 32'h0;
        default: write_mask_i = $urandom | 32'hFFFF_FF00;
      endcase
      inval_i = ($urandom_range(0, 99) < 20);
      inval_index_i = ($urandom_range(0, 3) == 0) ? write_index_i : 5'($urandom_range(0, 31));
      read_i = ($urandom_range(0, 1) == 1);
      read_index_i = ($urandom_range(0, 3) == 0) ? write_index_i : 5'($urandom_range(0, 31));
      search_i = ($urandom_range(0, 99) < 60);
      search_data_i = 32'($urandom_range(0, 9));
      cycle();
    end

    // Async reset mid-cycle
    write1(0, 32'h1, 32'h0);
    read_i = 1; read_index_i = 0; search_i = 1; search_data_i = 32'h1;
    cycle();
    chk("pre_reset_sv", search_valid_o, 1'b1);
    #1 reset_i = 1;
    #1;
    chk("async_reset_sv", search_valid_o, 1'b0);
    chk("async_reset_rv", read_valid_o, 1'b0);
    chk("async_reset_rval", read_value_o, 32'd0);
    chk("async_reset_count", count_o, 6'd0);
    model_reset();
    reset_i = 0;
    search1(32'h1);
    chk("post_reset_miss", search_valid_o, 1'b0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
